// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register file's single write port, merging
// single-cycle ALU results with in-order load returns, and keeps a per-register
// busy scoreboard so the issue stage can stall on pending loads.
// r15 reads as PC in the register file, so commits to r15 never raise write.
module wb_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int REGWIDTH  = 4,
    parameter int LDDEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REGWIDTH-1:0]  alu_dst,
    input  logic [DATAWIDTH-1:0] alu_data,
    input  logic                 ld_issue,
    input  logic [REGWIDTH-1:0]  ld_dst,
    output logic                 ld_ready,
    input  logic                 mem_valid,
    input  logic [DATAWIDTH-1:0] mem_data,
    output logic                 mem_ready,
    input  logic [REGWIDTH-1:0]  q_src,
    input  logic [REGWIDTH-1:0]  q_dst,
    output logic                 hazard,
    output logic                 write,
    output logic [REGWIDTH-1:0]  rDst,
    output logic [DATAWIDTH-1:0] write_data,
    output logic                 err
);

    localparam int NREG = 1 << REGWIDTH;
    localparam int PW   = $clog2(LDDEPTH);
    localparam int CW   = $clog2(LDDEPTH + 1);
    localparam logic [CW-1:0]       DEPTH_C = CW'(LDDEPTH);
    localparam logic [REGWIDTH-1:0] PC_REG  = {REGWIDTH{1'b1}};

    // Outstanding-load tag FIFO
    logic [REGWIDTH-1:0] fifo_r [LDDEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;

    // Return parked behind an ALU commit
    logic                 hold_v_r;
    logic [REGWIDTH-1:0]  hold_tag_r;
    logic [DATAWIDTH-1:0] hold_data_r;

    logic [NREG-1:0]      busy_r;
    logic                 write_r;
    logic [REGWIDTH-1:0]  rdst_r;
    logic [DATAWIDTH-1:0] wdata_r;
    logic                 err_r;

    logic                 ld_push_s;
    logic                 mem_acc_s;
    logic                 mem_err_s;
    logic                 alu_err_s;
    logic [REGWIDTH-1:0]  head_tag_s;
    logic                 commit_v_s;
    logic                 commit_ld_s;
    logic [REGWIDTH-1:0]  commit_dst_s;
    logic [DATAWIDTH-1:0] commit_data_s;
    logic                 hold_fill_s;
    logic                 hold_drain_s;
    logic [NREG-1:0]      clr_mask_s;
    logic [NREG-1:0]      set_mask_s;
    logic [NREG-1:0]      busy_next_s;

    assign ld_ready   = (count_r < DEPTH_C) & ~busy_r[ld_dst];
    assign mem_ready  = ~hold_v_r;
    assign hazard     = busy_r[q_src] | busy_r[q_dst];
    assign ld_push_s  = ld_issue & ld_ready;
    assign mem_acc_s  = mem_valid & ~hold_v_r & (count_r != {CW{1'b0}});
    // A return with no outstanding tag has nothing to pair with
    assign mem_err_s  = mem_valid & (count_r == {CW{1'b0}});
    assign alu_err_s  = alu_valid & busy_r[alu_dst];
    assign head_tag_s = fifo_r[rd_ptr_r];

    assign write      = write_r;
    assign rDst       = rdst_r;
    assign write_data = wdata_r;
    assign err        = err_r;

    // Commit selection: ALU beats the hold entry, which beats a direct return
    always_comb begin
        commit_v_s    = 1'b0;
        commit_ld_s   = 1'b0;
        commit_dst_s  = {REGWIDTH{1'b0}};
        commit_data_s = {DATAWIDTH{1'b0}};
        hold_fill_s   = 1'b0;
        hold_drain_s  = 1'b0;
        if (alu_valid) begin
            commit_v_s    = 1'b1;
            commit_dst_s  = alu_dst;
            commit_data_s = alu_data;
            hold_fill_s   = mem_acc_s;
        end else if (hold_v_r) begin
            commit_v_s    = 1'b1;
            commit_ld_s   = 1'b1;
            commit_dst_s  = hold_tag_r;
            commit_data_s = hold_data_r;
            hold_drain_s  = 1'b1;
            hold_fill_s   = mem_acc_s;
        end else if (mem_acc_s) begin
            commit_v_s    = 1'b1;
            commit_ld_s   = 1'b1;
            commit_dst_s  = head_tag_s;
            commit_data_s = mem_data;
        end else begin
            commit_v_s    = 1'b0;
        end
    end

    // Scoreboard update: a committing load clears, an accepted load sets (set wins)
    always_comb begin
        clr_mask_s  = commit_ld_s ? (NREG'(1) << commit_dst_s) : {NREG{1'b0}};
        set_mask_s  = (ld_push_s && (ld_dst != PC_REG)) ? (NREG'(1) << ld_dst) : {NREG{1'b0}};
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // State registers: tag FIFO, hold entry, scoreboard, write port and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LDDEPTH; i++) begin
                fifo_r[i] <= {REGWIDTH{1'b0}};
            end
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            hold_v_r    <= 1'b0;
            hold_tag_r  <= {REGWIDTH{1'b0}};
            hold_data_r <= {DATAWIDTH{1'b0}};
            busy_r      <= {NREG{1'b0}};
            write_r     <= 1'b0;
            rdst_r      <= {REGWIDTH{1'b0}};
            wdata_r     <= {DATAWIDTH{1'b0}};
            err_r       <= 1'b0;
        end else begin
            if (ld_push_s) begin
                fifo_r[wr_ptr_r] <= ld_dst;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (mem_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({ld_push_s, mem_acc_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (hold_fill_s) begin
                hold_v_r    <= 1'b1;
                hold_tag_r  <= head_tag_s;
                hold_data_r <= mem_data;
            end else if (hold_drain_s) begin
                hold_v_r <= 1'b0;
            end
            busy_r  <= busy_next_s;
            write_r <= commit_v_s & (commit_dst_s != PC_REG);
            if (commit_v_s) begin
                rdst_r  <= commit_dst_s;
                wdata_r <= commit_data_s;
            end
            if (mem_err_s | alu_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based model of outstanding loads.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_dst;
    logic        ld_ready;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [3:0]  q_src;
    logic [3:0]  q_dst;
    logic        hazard;
    logic        write;
    logic [3:0]  rDst;
    logic [15:0] write_data;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    bit comb_ok  = 1'b0;

    // Model: tags issued but not yet returned, plus the parked return
    logic [3:0]  pend[$];
    bit          hold_valid;
    logic [3:0]  hold_tag;
    logic [15:0] hold_data;
    logic        exp_write;
    logic [3:0]  exp_rdst;
    logic [15:0] exp_wdata;
    logic        exp_err;

    wb_arbiter #(.DATAWIDTH(16), .REGWIDTH(4), .LDDEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_ready(ld_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
        .q_src(q_src), .q_dst(q_dst), .hazard(hazard),
        .write(write), .rDst(rDst), .write_data(write_data), .err(err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A register is busy while a load to it is still outstanding or parked
    function automatic bit m_busy(input logic [3:0] r);
        if (r == 4'd15) return 1'b0;
        foreach (pend[i]) if (pend[i] == r) return 1'b1;
        if (hold_valid && hold_tag == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        reset = 1'b0; alu_valid = 1'b0; alu_dst = 4'd0; alu_data = 16'd0;
        ld_issue = 1'b0; ld_dst = 4'd0; mem_valid = 1'b0; mem_data = 16'd0;
        q_src = 4'd0; q_dst = 4'd0;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic tick();
        bit         e_ldr, e_mr, e_haz, acc, push, cv;
        logic [3:0] cd, t;
        logic [15:0] cdata;
        #1;
        e_ldr = (pend.size() < 4) && !m_busy(ld_dst);
        e_mr  = !hold_valid;
        e_haz = m_busy(q_src) || m_busy(q_dst);
        if (comb_ok) begin
            check_eq("ld_ready",  32'(ld_ready),  32'(e_ldr));
            check_eq("mem_ready", 32'(mem_ready), 32'(e_mr));
            check_eq("hazard",    32'(hazard),    32'(e_haz));
        end
        if (reset) begin
            pend.delete();
            hold_valid = 1'b0;
            exp_write = 1'b0; exp_rdst = 4'd0; exp_wdata = 16'd0; exp_err = 1'b0;
        end else begin
            acc  = mem_valid && e_mr && (pend.size() > 0);
            push = ld_issue && e_ldr;
            if (mem_valid && pend.size() == 0) exp_err = 1'b1;
            if (alu_valid && m_busy(alu_dst)) exp_err = 1'b1;
            t = 4'd0;
            if (acc) t = pend.pop_front();
            cv = 1'b0; cd = 4'd0; cdata = 16'd0;
            if (alu_valid) begin
                cv = 1'b1; cd = alu_dst; cdata = alu_data;
                if (acc) begin
                    hold_valid = 1'b1; hold_tag = t; hold_data = mem_data;
                end
            end else if (hold_valid) begin
                cv = 1'b1; cd = hold_tag; cdata = hold_data;
                hold_valid = 1'b0;
            end else if (acc) begin
                cv = 1'b1; cd = t; cdata = mem_data;
            end
            if (push) pend.push_back(ld_dst);
            exp_write = cv && (cd != 4'd15);
            if (cv) begin
                exp_rdst = cd; exp_wdata = cdata;
            end
        end
        @(posedge clk);
        #1;
        check_eq("write",      32'(write),      32'(exp_write));
        check_eq("rDst",       32'(rDst),       32'(exp_rdst));
        check_eq("write_data", 32'(write_data), 32'(exp_wdata));
        check_eq("err",        32'(err),        32'(exp_err));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && (pend.size() > 0 || hold_valid); k++) begin
            idle(); mem_valid = 1'b1; mem_data = 16'($urandom); tick();
        end
        idle();
    endtask

    // Directed scenarios then random traffic
    initial begin
        logic [3:0] wrap_dst [8];
        logic [3:0] wrap_ret [8];
        wrap_dst = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd0, 4'd1, 4'd2, 4'd3};
        wrap_ret = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd0};

        // Reset held two cycles with ALU traffic present
        idle(); reset = 1'b1; alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'hFFFF;
        tick();
        comb_ok = 1'b1;
        tick();
        idle(); #1;
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_wdata", 32'(write_data), 32'd0);
        check_eq("rst_ldrdy", 32'(ld_ready), 32'd1);
        check_eq("rst_memrdy", 32'(mem_ready), 32'd1);
        check_eq("rst_hazard", 32'(hazard), 32'd0);

        // ALU path, then a suppressed write to r15
        alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h1234; tick();
        check_eq("alu_write", 32'(write), 32'd1);
        check_eq("alu_rdst", 32'(rDst), 32'd3);
        check_eq("alu_data", 32'(write_data), 32'h1234);
        idle(); tick();
        check_eq("alu_pulse", 32'(write), 32'd0);
        alu_valid = 1'b1; alu_dst = 4'd15; alu_data = 16'h0F0F; tick();
        check_eq("alu_r15", 32'(write), 32'd0);

        // Loads and scoreboard
        idle(); ld_issue = 1'b1; ld_dst = 4'd2; tick();
        ld_dst = 4'd5; tick();
        idle(); q_src = 4'd2; ld_dst = 4'd2; #1;
        check_eq("sb_hazard", 32'(hazard), 32'd1);
        check_eq("sb_ldrdy", 32'(ld_ready), 32'd0);
        tick();
        mem_valid = 1'b1; mem_data = 16'hAAAA; tick();
        check_eq("ld1_rdst", 32'(rDst), 32'd2);
        check_eq("ld1_data", 32'(write_data), 32'hAAAA);
        check_eq("ld1_hazclr", 32'(hazard), 32'd0);
        mem_data = 16'h5555; tick();
        check_eq("ld2_rdst", 32'(rDst), 32'd5);

        // ALU / return conflict and hold-full back-pressure
        idle(); ld_issue = 1'b1; ld_dst = 4'd4; tick();
        ld_dst = 4'd8; tick();
        idle(); alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h0001;
        mem_valid = 1'b1; mem_data = 16'h00F0; tick();
        check_eq("cf_alu_rdst", 32'(rDst), 32'd1);
        idle(); mem_valid = 1'b1; mem_data = 16'h0F0F; #1;
        check_eq("cf_memrdy", 32'(mem_ready), 32'd0);
        tick();
        check_eq("cf_hold_rdst", 32'(rDst), 32'd4);
        check_eq("cf_hold_data", 32'(write_data), 32'h00F0);
        tick();
        check_eq("cf_late_rdst", 32'(rDst), 32'd8);
        check_eq("cf_late_data", 32'(write_data), 32'h0F0F);
        drain();

        // FIFO full, refused push during pop, then wrap
        for (int r = 6; r <= 9; r++) begin
            idle(); ld_issue = 1'b1; ld_dst = 4'(r); tick();
        end
        idle(); ld_issue = 1'b1; ld_dst = 4'd10; #1;
        check_eq("full_ldrdy", 32'(ld_ready), 32'd0);
        mem_valid = 1'b1; mem_data = 16'h6666; tick();
        check_eq("full_pop_rdst", 32'(rDst), 32'd6);
        mem_valid = 1'b0; tick();
        q_src = 4'd10; #1;
        check_eq("full_r10_busy", 32'(hazard), 32'd1);
        idle(); mem_valid = 1'b1; mem_data = 16'h7777; tick();
        check_eq("wrap_first", 32'(rDst), 32'd7);
        for (int i = 0; i < 8; i++) begin
            idle(); ld_issue = 1'b1; ld_dst = wrap_dst[i];
            mem_valid = 1'b1; mem_data = 16'($urandom); tick();
            check_eq("wrap_order", 32'(rDst), 32'(wrap_ret[i]));
        end
        drain();

        // Errors: stray return, ALU write to busy register, mid-flight reset
        idle(); mem_valid = 1'b1; tick();
        check_eq("stray_err", 32'(err), 32'd1);
        check_eq("stray_nowr", 32'(write), 32'd0);
        idle(); reset = 1'b1; tick();
        idle(); ld_issue = 1'b1; ld_dst = 4'd7; tick();
        idle(); alu_valid = 1'b1; alu_dst = 4'd7; alu_data = 16'hBEEF; tick();
        check_eq("busy_alu_err", 32'(err), 32'd1);
        idle(); q_src = 4'd7; #1;
        check_eq("busy_kept", 32'(hazard), 32'd1);
        mem_valid = 1'b1; mem_data = 16'h7007; tick();
        check_eq("busy_cleared", 32'(hazard), 32'd0);
        for (int r = 1; r <= 3; r++) begin
            idle(); ld_issue = 1'b1; ld_dst = 4'(r); tick();
        end
        idle(); reset = 1'b1; tick();
        idle(); q_src = 4'd1; q_dst = 4'd2; ld_dst = 4'd3; #1;
        check_eq("mid_rst_hazard", 32'(hazard), 32'd0);
        check_eq("mid_rst_ldrdy", 32'(ld_ready), 32'd1);
        mem_valid = 1'b1; tick();
        check_eq("mid_rst_count0", 32'(err), 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(99, 0) == 0);
            alu_valid = ($urandom_range(9, 0) < 3);
            alu_dst   = 4'($urandom);
            alu_data  = 16'($urandom);
            ld_issue  = ($urandom_range(9, 0) < 4);
            ld_dst    = 4'($urandom);
            if (pend.size() > 0 || hold_valid) mem_valid = ($urandom_range(9, 0) < 5);
            else mem_valid = ($urandom_range(29, 0) == 0);
            mem_data  = 16'($urandom);
            q_src     = 4'($urandom);
            q_dst     = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
